weight_stream_reader: RTL
=========================

WEIGHT_STREAM_READER -- requirements
Module: weight_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 28, meaning number of weight words per layer column to fetch.
REQ-002 SHALL have parameter DW, default 16, meaning weight word width.
REQ-003 SHALL have parameter AW, default 5, meaning BRAM address width.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on posedge CLK.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port START  input  1  one-cycle request to stream all DEPTH words.
REQ-007 SHALL have port BRAM_ADDR  output  AW  weight BRAM address.
REQ-008 SHALL have port BRAM_EN  output  1  weight BRAM enable.
REQ-009 SHALL have port BRAM_WE  output  1  weight BRAM write enable, constant 0.
REQ-010 SHALL have port BRAM_DI  output  DW  weight BRAM write data, constant 0.
REQ-011 SHALL have port BRAM_DO  input  DW  weight BRAM read data, updated on negedge CLK after the BRAM samples EN/ADDR.
REQ-012 SHALL have port W_DATA  output  DW  streamed weight word.
REQ-013 SHALL have port W_INDEX  output  AW  address the current W_DATA came from.
REQ-014 SHALL have port W_VALID  output  1  W_DATA/W_INDEX/W_LAST valid.
REQ-015 SHALL have port W_READY  input  1  consumer accepts; transfer when W_VALID and W_READY at posedge.
REQ-016 SHALL have port W_LAST  output  1  high with the word at index DEPTH-1.
REQ-017 SHALL have port BUSY  output  1  high from START acceptance until DONE.
REQ-018 SHALL have port DONE  output  1  one-cycle pulse after the last transfer.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN, FINISH.
REQ-020 SHALL move IDLE->FETCH when START=1 at a posedge; START in any other state SHALL be ignored.
REQ-021 SHALL, in FETCH, issue one read per cycle (BRAM_EN=1, BRAM_ADDR=next address from 0 to DEPTH-1) only while fifo_count + inflight < 3, inflight being the read issued the previous cycle; otherwise BRAM_EN=0 and BRAM_ADDR holds.
REQ-022 SHALL capture BRAM_DO at the posedge following an issued read and push it with its address into the 3-entry FIFO; read latency is one cycle.
REQ-023 SHALL move FETCH->DRAIN in the cycle after address DEPTH-1 is issued; DRAIN->FINISH on the W_LAST transfer; FINISH->IDLE after one cycle with DONE=1.
REQ-024 SHALL drive W_DATA/W_INDEX/W_LAST from the FIFO head; W_VALID = FIFO non-empty; outputs SHALL stay stable while W_VALID=1 and W_READY=0.
REQ-025 SHALL sustain one transfer per cycle with W_READY held high; first W_VALID two cycles after START is sampled; last transfer DEPTH+1 cycles after START; DONE one cycle later.
REQ-026 SHALL never overflow the FIFO under any W_READY pattern and never lose or duplicate a word.
REQ-027 SHALL have no combinational path from W_READY to BRAM_EN or BRAM_ADDR.
REQ-028 SHALL handle a simultaneous push and pop in one cycle with the FIFO count unchanged.

Reset
REQ-029 SHALL, on RST=1 at a posedge, enter IDLE, flush the FIFO and inflight flag, and drive BRAM_ADDR=0, BRAM_EN=0, W_VALID=0, W_LAST=0, W_DATA=0, W_INDEX=0, BUSY=0, DONE=0.
REQ-030 SHALL discard a read in flight when RST is asserted mid-stream; no W_VALID SHALL follow reset until a new START.

Structure
REQ-031 SHALL take DEPTH, DW, AW defaults and the state encoding from shared package weight_pkg.
REQ-032 SHALL instantiate one sub-module weight_skid_fifo (3-entry, DW+AW+1 wide, synchronous reset).

Verification (BRAM model: negedge read, word[i]=16'h0100+i, DEPTH=28)
REQ-033 SHALL verify: START, W_READY=1 -> 28 transfers on consecutive cycles, data 16'h0100..16'h011B, W_LAST only on index 27, DONE one cycle later.
REQ-034 SHALL verify: W_READY=0 for 10 cycles after START -> at most 3 reads issued, W_DATA=16'h0100 held stable, then correct in-order stream.
REQ-035 SHALL verify: W_READY toggled 1/0 each cycle -> 28 in-order words, no loss or duplication, BRAM_EN never asserted with fifo_count+inflight=3.
REQ-036 SHALL verify: RST at transfer index 12 -> all outputs 0 next cycle, no W_VALID until new START, new stream starts at index 0.
REQ-037 SHALL verify: START pulsed again during FETCH -> ignored, exactly 28 transfers, one DONE.
REQ-038 SHALL verify: BRAM_WE=0 and BRAM_DI=0 on every cycle of all scenarios.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared definitions for the weight streaming path.
//   DEPTH_DEF / DW_DEF / AW_DEF : default column depth, word width, address width
//   rd_state_t                  : reader FSM encoding
package weight_pkg;

   localparam int DEPTH_DEF = 28;
   localparam int DW_DEF    = 16;
   localparam int AW_DEF    = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } rd_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Three-entry FIFO that absorbs BRAM read data while the consumer stalls.
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   push       : write push_data this cycle
//   pop        : remove the head entry this cycle (ignored when empty)
//   head_data  : current head entry, forced to zero while empty
//   count      : number of stored entries (0..3)
//   not_empty  : at least one entry stored
// Handshake: an entry leaves only when pop is high while not_empty is high;
// the head entry does not change while it is not popped.
module weight_skid_fifo #(
   parameter int WIDTH = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count,
   output logic             not_empty
);

   logic [WIDTH-1:0] mem [0:2];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign not_empty = (count != 2'd0);
   assign do_pop    = pop && not_empty;
   // A push into a full FIFO is accepted only when the head leaves the same cycle.
   assign do_push   = push && ((count != 2'd3) || do_pop);
   assign head_data = not_empty ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 2'd0;
         for (int i = 0; i < 3; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/weight_stream_reader.sv
// Streams DEPTH weight words out of a BRAM (one-cycle read latency) into a
// valid/ready consumer, throttling reads so the 3-entry FIFO never overflows.
//   CLK, RST            : clock, synchronous active-high reset
//   START               : one-cycle request, accepted only in IDLE
//   BRAM_ADDR/EN/WE/DI  : BRAM read port (WE and DI tied to zero)
//   BRAM_DO             : BRAM read data, valid the cycle after a read is issued
//   W_DATA/W_INDEX/W_LAST/W_VALID, W_READY : output stream
//   BUSY, DONE          : activity flag and end-of-stream pulse
//   DBG_STATE           : current FSM state
// Handshake: a word transfers at a posedge where W_VALID and W_READY are both
// high; while W_VALID is high and W_READY low, W_DATA/W_INDEX/W_LAST hold.
module weight_stream_reader
   import weight_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   output logic [AW-1:0] BRAM_ADDR,
   output logic          BRAM_EN,
   output logic          BRAM_WE,
   output logic [DW-1:0] BRAM_DI,
   input  logic [DW-1:0] BRAM_DO,
   output logic [DW-1:0] W_DATA,
   output logic [AW-1:0] W_INDEX,
   output logic          W_VALID,
   input  logic          W_READY,
   output logic          W_LAST,
   output logic          BUSY,
   output logic          DONE,
   output rd_state_t     DBG_STATE
);

   localparam int            FW        = DW + AW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   rd_state_t     state_q, state_d;
   logic [AW-1:0] rd_ptr_q;     // next address to issue
   logic [AW-1:0] addr_q;       // most recently issued address
   logic          inflight_q;   // a read was issued last cycle
   logic          issue;
   logic [1:0]    fifo_count;
   logic [2:0]    occupancy;
   logic [FW-1:0] push_data;
   logic [FW-1:0] head_data;
   logic          pop;

   // Occupancy uses only registered state, so W_READY never reaches BRAM_EN/ADDR.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE:   if (START) state_d = FETCH;
         FETCH: begin
            if (occupancy < 3'd3) begin
               issue = 1'b1;
               if (rd_ptr_q == LAST_ADDR) state_d = DRAIN;
            end
         end
         DRAIN:  if (pop && W_LAST) state_d = FINISH;
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (state_q == IDLE && START) rd_ptr_q <= '0;
         if (issue) begin
            addr_q   <= rd_ptr_q;
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   assign BRAM_EN   = issue;
   assign BRAM_ADDR = issue ? rd_ptr_q : addr_q;
   assign BRAM_WE   = 1'b0;
   assign BRAM_DI   = '0;

   // addr_q still names the read whose data is on BRAM_DO this cycle.
   assign push_data = {(addr_q == LAST_ADDR), addr_q, BRAM_DO};
   assign pop       = W_VALID && W_READY;

   weight_skid_fifo #(.WIDTH(FW)) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (inflight_q),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count),
      .not_empty (W_VALID)
   );

   assign {W_LAST, W_INDEX, W_DATA} = head_data;
   assign BUSY      = (state_q != IDLE);
   assign DONE      = (state_q == FINISH);
   assign DBG_STATE = state_q;

endmodule
